// File: rtl/alu_pipe.sv
// Pipelined WIDTH-bit ALU with a registered result stage, valid/ready handshake and an accumulator.
// Optional ALU_SAT_EN makes ADD/SUB/ACC saturate on signed overflow; the default build wraps.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       OpCode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             OVFlag,
   output logic             CFlag,
   output logic             ZFlag
);

   localparam logic [2:0] OP_SUB = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_NOT = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_ACC = 3'd7;

`ifdef ALU_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] add_x;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] res_c;
   logic             ovf_c;
   logic             cy_c;
   logic             accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // ACC reuses the adder with the accumulator as the first operand
   assign add_x = (OpCode == OP_ACC) ? acc : a;
   assign sum   = {1'b0, add_x} + {1'b0, ((OpCode == OP_ACC) ? a : b)};
   assign diff  = {1'b0, a} - {1'b0, b};

   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      cy_c  = 1'b0;
      case (OpCode)
         OP_SUB: begin
            res_c = diff[WIDTH-1:0];
            cy_c  = diff[WIDTH];
            ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ADD, OP_ACC: begin
            res_c = sum[WIDTH-1:0];
            cy_c  = sum[WIDTH];
            ovf_c = (add_x[WIDTH-1] == ((OpCode == OP_ACC) ? a[WIDTH-1] : b[WIDTH-1]))
                    && (sum[WIDTH-1] != add_x[WIDTH-1]);
         end
         OP_NOT:  res_c = ~a;
         OP_OR:   res_c = a | b;
         OP_AND:  res_c = a & b;
         OP_XOR:  res_c = a ^ b;
         OP_SHL:  res_c = a << b[SHW-1:0];
         default: res_c = '0;
      endcase
`ifdef ALU_SAT_EN
      // On overflow the wrapped sign is the inverse of the true sign
      if (ovf_c)
         res_c = res_c[WIDTH-1] ? SAT_MAX : SAT_MIN;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         r         <= '0;
         OVFlag    <= 1'b0;
         CFlag     <= 1'b0;
         ZFlag     <= 1'b0;
         acc       <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         r         <= res_c;
         OVFlag    <= ovf_c;
         CFlag     <= cy_c;
         ZFlag     <= (res_c == '0);
         if (OpCode == OP_ACC)
            acc <= res_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8, default wrapping build).
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] OpCode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] r;
   logic       OVFlag;
   logic       CFlag;
   logic       ZFlag;

   int checks   = 0;
   int failures = 0;

   alu_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .OpCode(OpCode), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .OVFlag(OVFlag), .CFlag(CFlag), .ZFlag(ZFlag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] er,
                          input logic eov, input logic ec, input logic ez);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".r"},     32'(r),         32'(er));
      chk({tag, ".ov"},    32'(OVFlag),    32'(eov));
      chk({tag, ".c"},     32'(CFlag),     32'(ec));
      chk({tag, ".z"},     32'(ZFlag),     32'(ez));
   endtask

   // One accepted operation: inputs presented, one edge, then sampled 1 ns later
   task automatic op(input logic [2:0] opc, input logic [7:0] va, input logic [7:0] vb);
      OpCode   = opc;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; OpCode = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("reset.in_ready", 32'(in_ready), 32'd1);

      op(3'd1, 8'h7F, 8'h01); chk_out("add_ovf", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
      op(3'd1, 8'hFF, 8'h01); chk_out("add_carry", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
      op(3'd0, 8'h80, 8'h01); chk_out("sub_ovf", 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
      op(3'd0, 8'h03, 8'h05); chk_out("sub_borrow", 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
      op(3'd2, 8'hF0, 8'h3C); chk_out("not", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      op(3'd3, 8'hF0, 8'h3C); chk_out("or",  1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);
      op(3'd4, 8'hF0, 8'h3C); chk_out("and", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
      op(3'd5, 8'hF0, 8'h3C); chk_out("xor", 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
      op(3'd6, 8'h81, 8'h03); chk_out("shl", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
      op(3'd4, 8'hFF, 8'h00); chk_out("and_zero", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

      op(3'd7, 8'h10, 8'hAA); chk_out("acc1", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      op(3'd7, 8'h20, 8'h55); chk_out("acc2", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
      op(3'd7, 8'hF0, 8'h00); chk_out("acc3", 1'b1, 8'h20, 1'b0, 1'b1, 1'b0);

      // Deliver with nothing offered: valid drops, r holds
      @(posedge clk); #1;
      chk_out("drain", 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);

      // Backpressure with an ACC waiting at the input
      op(3'd1, 8'h05, 8'h03); chk_out("bp_load", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      OpCode = 3'd7; a = 8'h11; b = 8'h00; in_valid = 1'b1;
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_out("bp_hold", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
         chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk_out("bp_release", 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);

      // Reset with a held result and an offered ACC
      out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk_out("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      op(3'd7, 8'h05, 8'h00); chk_out("acc_after_rst", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
